// File: rtl/decode_issue_if.sv
// Fetch-side, register-file, forwarding, hazard and execute-side signals of the decode/issue stage.
// The slave modport is the stage's view of these signals. The master modport is the surrounding pipeline's view.
interface decode_issue_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NFWD = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic [XLEN-1:0]      in_pc;
    logic [XLEN-1:0]      in_imm;
    logic [31:0]          in_instr;
    logic                 in_rs1_used;
    logic                 in_rs2_used;
    logic                 in_rd_we;
    logic                 in_is_load;
    logic                 in_multicycle;
    logic [4:0]           rf_raddr1;
    logic [4:0]           rf_raddr2;
    logic [XLEN-1:0]      rf_rdata1;
    logic [XLEN-1:0]      rf_rdata2;
    logic [NFWD-1:0]      fwd_valid;
    logic [5*NFWD-1:0]    fwd_dst;
    logic [XLEN*NFWD-1:0] fwd_data;
    logic                 ex_load_valid;
    logic [4:0]           ex_load_dst;
    logic                 mc_done;
    logic [4:0]           mc_dst;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_pc;
    logic [XLEN-1:0]      out_imm;
    logic [XLEN-1:0]      out_srca;
    logic [XLEN-1:0]      out_srcb;
    logic [31:0]          out_instr;
    logic [4:0]           out_rs1;
    logic [4:0]           out_rs2;
    logic [4:0]           out_dst;
    logic                 out_rd_we;
    logic                 out_is_load;
    logic                 out_multicycle;
    logic                 stall;

    modport slave (
        input  in_valid, in_pc, in_imm, in_instr, in_rs1_used, in_rs2_used,
               in_rd_we, in_is_load, in_multicycle, rf_rdata1, rf_rdata2,
               fwd_valid, fwd_dst, fwd_data, ex_load_valid, ex_load_dst,
               mc_done, mc_dst, flush, out_ready,
        output in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_imm,
               out_srca, out_srcb, out_instr, out_rs1, out_rs2, out_dst,
               out_rd_we, out_is_load, out_multicycle, stall
    );

    modport master (
        output in_valid, in_pc, in_imm, in_instr, in_rs1_used, in_rs2_used,
               in_rd_we, in_is_load, in_multicycle, rf_rdata1, rf_rdata2,
               fwd_valid, fwd_dst, fwd_data, ex_load_valid, ex_load_dst,
               mc_done, mc_dst, flush, out_ready,
        input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_imm,
               out_srca, out_srcb, out_instr, out_rs1, out_rs2, out_dst,
               out_rd_we, out_is_load, out_multicycle, stall
    );
endinterface

// File: rtl/decode_issue.sv
// Decode/issue stage: priority operand forwarding, load-use and scoreboard hazards, registered ID/EX slot.
// Define DECODE_SCOREBOARD_EN to build the multicycle busy-vector scoreboard.
module decode_issue #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NFWD = 2
) (
    input logic          clk,
    input logic          reset,
    decode_issue_if.slave bus
);
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] srca_d, srcb_d;
    logic            load_use, sb_hazard, stall, ready, accept;
    logic            out_valid_q, out_valid_d;

    logic [XLEN-1:0] out_pc_q, out_imm_q, out_srca_q, out_srcb_q;
    logic [31:0]     out_instr_q;
    logic [4:0]      out_rs1_q, out_rs2_q, out_dst_q;
    logic            out_rd_we_q, out_is_load_q, out_multicycle_q;

    logic [NFWD-1:0]      v_sh;
    logic [5*NFWD-1:0]    d_sh;
    logic [XLEN*NFWD-1:0] x_sh;

    assign rs1 = bus.in_instr[19:15];
    assign rs2 = bus.in_instr[24:20];
    assign rd  = bus.in_instr[11:7];

    assign bus.rf_raddr1 = rs1;
    assign bus.rf_raddr2 = rs2;

    // Walk from the oldest source down so the lowest matching index is written last and wins.
    always_comb begin
        srca_d = bus.rf_rdata1;
        srcb_d = bus.rf_rdata2;
        v_sh   = '0;
        d_sh   = '0;
        x_sh   = '0;
        for (int unsigned i = NFWD; i > 0; i--) begin
            v_sh = bus.fwd_valid >> (i - 1);
            d_sh = bus.fwd_dst >> (5 * (i - 1));
            x_sh = bus.fwd_data >> (XLEN * (i - 1));
            if (v_sh[0] && d_sh[4:0] == rs1) srca_d = x_sh[XLEN-1:0];
            if (v_sh[0] && d_sh[4:0] == rs2) srcb_d = x_sh[XLEN-1:0];
        end
        if (rs1 == '0) srca_d = '0;
        if (rs2 == '0) srcb_d = '0;
    end

    assign load_use = bus.ex_load_valid && (bus.ex_load_dst != '0) &&
                      ((bus.in_rs1_used && rs1 == bus.ex_load_dst) ||
                       (bus.in_rs2_used && rs2 == bus.ex_load_dst));

`ifdef DECODE_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    assign sb_hazard = (bus.in_rs1_used && busy_q[rs1]) ||
                       (bus.in_rs2_used && busy_q[rs2]) ||
                       (bus.in_rd_we && busy_q[rd]);

    always_comb begin
        busy_d = busy_q;
        if (bus.mc_done && bus.mc_dst != '0) busy_d[bus.mc_dst] = 1'b0;
        if (accept && bus.in_multicycle && bus.in_rd_we && rd != '0) busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end
`else
    logic unused_mc;
    assign unused_mc = ^{bus.mc_done, bus.mc_dst};
    assign sb_hazard = 1'b0;
`endif

    assign stall  = bus.in_valid && (load_use || sb_hazard);
    assign ready  = !bus.flush && !stall && (!out_valid_q || bus.out_ready);
    assign accept = bus.in_valid && ready;

    assign bus.stall    = stall;
    assign bus.in_ready = ready;

    always_comb begin
        out_valid_d = out_valid_q;
        if (bus.flush)          out_valid_d = 1'b0;
        else if (accept)        out_valid_d = 1'b1;
        else if (bus.out_ready) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q      <= 1'b0;
            out_pc_q         <= '0;
            out_imm_q        <= '0;
            out_srca_q       <= '0;
            out_srcb_q       <= '0;
            out_instr_q      <= '0;
            out_rs1_q        <= '0;
            out_rs2_q        <= '0;
            out_dst_q        <= '0;
            out_rd_we_q      <= 1'b0;
            out_is_load_q    <= 1'b0;
            out_multicycle_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                out_pc_q         <= bus.in_pc;
                out_imm_q        <= bus.in_imm;
                out_srca_q       <= srca_d;
                out_srcb_q       <= srcb_d;
                out_instr_q      <= bus.in_instr;
                out_rs1_q        <= rs1;
                out_rs2_q        <= rs2;
                out_dst_q        <= rd;
                out_rd_we_q      <= bus.in_rd_we;
                out_is_load_q    <= bus.in_is_load;
                out_multicycle_q <= bus.in_multicycle;
            end
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_imm        = out_imm_q;
    assign bus.out_srca       = out_srca_q;
    assign bus.out_srcb       = out_srcb_q;
    assign bus.out_instr      = out_instr_q;
    assign bus.out_rs1        = out_rs1_q;
    assign bus.out_rs2        = out_rs2_q;
    assign bus.out_dst        = out_dst_q;
    assign bus.out_rd_we      = out_rd_we_q;
    assign bus.out_is_load    = out_is_load_q;
    assign bus.out_multicycle = out_multicycle_q;
endmodule

// File: tb/tb_decode_issue.sv
// Randomized and directed bench for decode_issue against a behavioural model of the issue slot.
// Scoreboard checks are included when DECODE_SCOREBOARD_EN is defined.
module tb_decode_issue;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_issue_if #(.XLEN(64), .NFWD(2)) bus ();
    decode_issue #(.XLEN(64), .NFWD(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks   = 0;
    int failures = 0;

    bit          m_valid, m_we, m_ld, m_mc;
    logic [63:0] m_pc, m_imm, m_a, m_b;
    logic [31:0] m_instr;
    logic [4:0]  m_rs1, m_rs2, m_dst;
    bit          m_busy [32];
    logic        obs_stall, obs_ready;
    logic [31:0] held, nxt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] opnd(input logic [4:0] r, input logic [63:0] rf);
        if (r == 5'd0) return 64'd0;
        for (int i = 0; i < 2; i++)
            if (bus.fwd_valid[i] && bus.fwd_dst[i*5 +: 5] == r) return bus.fwd_data[i*64 +: 64];
        return rf;
    endfunction

    task automatic clear_inputs();
        reset = 1'b1;
        bus.in_valid = 0; bus.in_pc = '0; bus.in_imm = '0; bus.in_instr = '0;
        bus.in_rs1_used = 0; bus.in_rs2_used = 0; bus.in_rd_we = 0;
        bus.in_is_load = 0; bus.in_multicycle = 0;
        bus.rf_rdata1 = '0; bus.rf_rdata2 = '0;
        bus.fwd_valid = '0; bus.fwd_dst = '0; bus.fwd_data = '0;
        bus.ex_load_valid = 0; bus.ex_load_dst = '0;
        bus.mc_done = 0; bus.mc_dst = '0; bus.flush = 0; bus.out_ready = 1;
    endtask

    task automatic set_instr(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                             input bit u1, input bit u2, input bit we, input bit ld, input bit mc);
        logic [31:0] w;
        w = $urandom;
        w[19:15] = r1; w[24:20] = r2; w[11:7] = rd;
        bus.in_instr = w;
        bus.in_pc = {$urandom, $urandom}; bus.in_imm = {$urandom, $urandom};
        bus.in_rs1_used = u1; bus.in_rs2_used = u2; bus.in_rd_we = we;
        bus.in_is_load = ld; bus.in_multicycle = mc;
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        logic [4:0] r1, r2, rd;
        bit lu, sb, stl, rdy, acc;
        #1;
        r1 = bus.in_instr[19:15]; r2 = bus.in_instr[24:20]; rd = bus.in_instr[11:7];
        lu = bus.ex_load_valid && bus.ex_load_dst != 0 &&
             ((bus.in_rs1_used && r1 == bus.ex_load_dst) || (bus.in_rs2_used && r2 == bus.ex_load_dst));
        sb = 0;
`ifdef DECODE_SCOREBOARD_EN
        sb = (bus.in_rs1_used && m_busy[r1]) || (bus.in_rs2_used && m_busy[r2]) ||
             (bus.in_rd_we && m_busy[rd]);
`endif
        stl = bus.in_valid && (lu || sb);
        rdy = !bus.flush && !stl && (!m_valid || bus.out_ready);
        acc = bus.in_valid && rdy;
        obs_stall = bus.stall;
        obs_ready = bus.in_ready;
        check("stall", bus.stall, stl);
        check("in_ready", bus.in_ready, rdy);
        check("rf_raddr1", bus.rf_raddr1, r1);
        check("rf_raddr2", bus.rf_raddr2, r2);
        if (!reset) begin
            m_valid = 0; m_pc = 0; m_imm = 0; m_a = 0; m_b = 0; m_instr = 0;
            m_rs1 = 0; m_rs2 = 0; m_dst = 0; m_we = 0; m_ld = 0; m_mc = 0;
            foreach (m_busy[k]) m_busy[k] = 0;
        end else begin
`ifdef DECODE_SCOREBOARD_EN
            if (bus.mc_done && bus.mc_dst != 0) m_busy[bus.mc_dst] = 0;
            if (acc && bus.in_multicycle && bus.in_rd_we && rd != 0) m_busy[rd] = 1;
`endif
            if (bus.flush) m_valid = 0;
            else if (acc) begin
                m_valid = 1; m_pc = bus.in_pc; m_imm = bus.in_imm;
                m_a = opnd(r1, bus.rf_rdata1); m_b = opnd(r2, bus.rf_rdata2);
                m_instr = bus.in_instr; m_rs1 = r1; m_rs2 = r2; m_dst = rd;
                m_we = bus.in_rd_we; m_ld = bus.in_is_load; m_mc = bus.in_multicycle;
            end else if (bus.out_ready) m_valid = 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", bus.out_valid, m_valid);
        check("out_pc", bus.out_pc, m_pc);
        check("out_imm", bus.out_imm, m_imm);
        check("out_srca", bus.out_srca, m_a);
        check("out_srcb", bus.out_srcb, m_b);
        check("out_instr", bus.out_instr, m_instr);
        check("out_rs1", bus.out_rs1, m_rs1);
        check("out_rs2", bus.out_rs2, m_rs2);
        check("out_dst", bus.out_dst, m_dst);
        check("out_rd_we", bus.out_rd_we, m_we);
        check("out_is_load", bus.out_is_load, m_ld);
        check("out_multicycle", bus.out_multicycle, m_mc);
        @(negedge clk);
    endtask

    task automatic randomize_inputs();
        set_instr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), ($urandom_range(0, 2) == 0));
        reset = ($urandom_range(0, 49) != 0);
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.rf_rdata1 = {$urandom, $urandom}; bus.rf_rdata2 = {$urandom, $urandom};
        bus.fwd_valid = 2'($urandom);
        bus.fwd_dst = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        bus.fwd_data = {$urandom, $urandom, $urandom, $urandom};
        bus.ex_load_valid = ($urandom_range(0, 3) == 0);
        bus.ex_load_dst = 5'($urandom_range(0, 7));
        bus.mc_done = ($urandom_range(0, 3) == 0);
        bus.mc_dst = 5'($urandom_range(0, 7));
        bus.flush = ($urandom_range(0, 15) == 0);
        bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        clear_inputs();
        foreach (m_busy[k]) m_busy[k] = 0;
        @(negedge clk);
        reset = 0;
        step();
        step();
        check("reset_valid", bus.out_valid, 64'd0);
        reset = 1;

        // Lowest-index forwarding source wins over the older one and the register file.
        bus.in_valid = 1;
        set_instr(5'd5, 5'd1, 5'd2, 1, 0, 0, 0, 0);
        bus.fwd_valid = 2'b11; bus.fwd_dst = {5'd5, 5'd5}; bus.fwd_data = {64'h22, 64'h11};
        bus.rf_rdata1 = 64'h99;
        step();
        check("fwd_prio", bus.out_srca, 64'h11);

        set_instr(5'd1, 5'd0, 5'd2, 1, 1, 0, 0, 0);
        bus.fwd_valid = 2'b01; bus.fwd_dst = {5'd3, 5'd0}; bus.fwd_data = {64'h1, 64'hdead};
        bus.rf_rdata2 = 64'h55;
        step();
        check("x0_guard", bus.out_srcb, 64'd0);

        clear_inputs();
        bus.in_valid = 1; bus.ex_load_valid = 1; bus.ex_load_dst = 5'd7;
        set_instr(5'd7, 5'd1, 5'd2, 1, 0, 1, 0, 0);
        step();
        check("lu_stall", obs_stall, 64'd1);
        check("lu_ready", obs_ready, 64'd0);
        bus.ex_load_valid = 0;
        step();
        check("lu_release", bus.out_valid, 64'd1);
        check("lu_rs1", bus.out_rs1, 64'd7);

`ifdef DECODE_SCOREBOARD_EN
        clear_inputs();
        bus.in_valid = 1;
        set_instr(5'd1, 5'd2, 5'd9, 1, 1, 1, 0, 1);
        step();
        set_instr(5'd9, 5'd0, 5'd4, 1, 0, 1, 0, 0);
        step();
        check("sb_stall", obs_stall, 64'd1);
        bus.mc_done = 1; bus.mc_dst = 5'd9;
        step();
        check("sb_same_cycle", obs_stall, 64'd1);
        bus.mc_done = 0;
        step();
        check("sb_release", obs_stall, 64'd0);
        check("sb_issued", bus.out_rs1, 64'd9);
`endif

        clear_inputs();
        bus.in_valid = 1;
        set_instr(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0);
        held = bus.in_instr;
        step();
        bus.out_ready = 0;
        set_instr(5'd4, 5'd5, 5'd6, 1, 1, 1, 0, 0);
        nxt = bus.in_instr;
        step();
        check("bp_ready", obs_ready, 64'd0);
        check("bp_hold", bus.out_instr, held);
        check("bp_valid", bus.out_valid, 64'd1);
        bus.flush = 1;
        step();
        check("flush_valid", bus.out_valid, 64'd0);
        check("flush_noconsume", bus.out_instr, held);
        bus.flush = 0; bus.out_ready = 1;
        step();
        check("after_flush", bus.out_instr, nxt);

        clear_inputs();
        bus.in_valid = 1;
        set_instr(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 1);
        step();
        reset = 0; bus.in_valid = 0;
        step();
        check("rst_valid", bus.out_valid, 64'd0);
        reset = 1; bus.in_valid = 1;
        set_instr(5'd3, 5'd0, 5'd5, 1, 0, 1, 0, 0);
        step();
        check("rst_nostall", obs_stall, 64'd0);
        check("rst_issue", bus.out_rs1, 64'd3);

        for (int n = 0; n < 500; n++) begin
            randomize_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
